proc_control_unit: RTL and testbench

//   Multi-cycle control FSM for the 16-bit bus processor. Holds the instruction register and sequences
//   one instruction at a time over time steps T0..T3. Drives the one-hot select of the 10:1 bus

---
 rtl/proc_pkg.sv | 50 +++++
 rtl/dec3to8.sv | 14 +
 rtl/proc_control_unit.sv | 131 +++++++++++++
 tb/tb_proc_control_unit.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/proc_pkg.sv
// Shared encodings for the bus processor control path: opcodes, time steps,
// one-hot bus mux selects and ALU operation codes.
package proc_pkg;

    localparam logic [2:0] OP_MV  = 3'b000;
    localparam logic [2:0] OP_MVI = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;
    localparam logic [2:0] OP_AND = 3'b100;
    localparam logic [2:0] OP_OR  = 3'b101;

    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } step_t;

    localparam logic [9:0] SEL_R0  = 10'b00_0000_0001;
    localparam logic [9:0] SEL_R1  = 10'b00_0000_0010;
    localparam logic [9:0] SEL_R2  = 10'b00_0000_0100;
    localparam logic [9:0] SEL_R3  = 10'b00_0000_1000;
    localparam logic [9:0] SEL_R4  = 10'b00_0001_0000;
    localparam logic [9:0] SEL_R5  = 10'b00_0010_0000;
    localparam logic [9:0] SEL_R6  = 10'b00_0100_0000;
    localparam logic [9:0] SEL_R7  = 10'b00_1000_0000;
    localparam logic [9:0] SEL_G   = 10'b01_0000_0000;
    localparam logic [9:0] SEL_DIN = 10'b10_0000_0000;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_OR  = 2'b11;

    function automatic logic is_alu_op(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR);
    endfunction

    function automatic logic [1:0] alu_code(input logic [2:0] op);
        logic [1:0] code;
        case (op)
            OP_SUB:  code = ALU_SUB;
            OP_AND:  code = ALU_AND;
            OP_OR:   code = ALU_OR;
            default: code = ALU_ADD;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/dec3to8.sv
// 3-bit to 8-bit one-hot decoder with enable; all outputs low when disabled.
module dec3to8 (
    input  logic       i_en,
    input  logic [2:0] i_sel,
    output logic [7:0] o_onehot
);

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_dec
            assign o_onehot[gi] = i_en && (i_sel == 3'(gi));
        end
    endgenerate

endmodule

// File: rtl/proc_control_unit.sv
// Multi-cycle control FSM of the 16-bit bus processor: holds IR, sequences T0..T3
// and decodes bus select, load enables, ALU op, Done and Busy from (step, IR).
module proc_control_unit
    import proc_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int IR_W   = 9
) (
    input  logic              i_clock,
    input  logic              i_resetn,
    input  logic              i_run,
    input  logic [DATA_W-1:0] i_din,
    output logic [9:0]        o_bus_sel,
    output logic [7:0]        o_rin,
    output logic              o_ain,
    output logic              o_gin,
    output logic [1:0]        o_alu_op,
    output logic              o_done,
    output logic              o_busy
);

    step_t            r_step;
    step_t            w_step_next;
    logic [IR_W-1:0]  r_ir;
    logic [2:0]       w_op;
    logic [2:0]       w_rx;
    logic [2:0]       w_ry;
    logic             w_rin_en;
    logic             w_bus_reg_en;
    logic             w_bus_use_ry;
    logic             w_sel_g;
    logic [2:0]       w_bus_reg_idx;
    logic [7:0]       w_bus_reg_onehot;
    logic             w_din_unused;

    // Only the low IR_W bits of Din carry the instruction.
    assign w_din_unused = ^i_din[DATA_W-1:IR_W];

    assign w_op = r_ir[8:6];
    assign w_rx = r_ir[5:3];
    assign w_ry = r_ir[2:0];

    always_ff @(posedge i_clock or negedge i_resetn) begin
        if (!i_resetn) begin
            r_step <= T0;
            r_ir   <= '0;
        end else begin
            r_step <= w_step_next;
            if (r_step == T0 && i_run) begin
                r_ir <= i_din[IR_W-1:0];
            end
        end
    end

    always_comb begin
        w_step_next  = T0;
        w_rin_en     = 1'b0;
        w_bus_reg_en = 1'b0;
        w_bus_use_ry = 1'b0;
        w_sel_g      = 1'b0;
        o_ain        = 1'b0;
        o_gin        = 1'b0;
        o_alu_op     = ALU_ADD;
        o_done       = 1'b0;
        o_busy       = 1'b1;
        case (r_step)
            T0: begin
                o_busy      = 1'b0;
                w_step_next = i_run ? T1 : T0;
            end
            T1: begin
                case (w_op)
                    OP_MV: begin
                        w_bus_reg_en = 1'b1;
                        w_bus_use_ry = 1'b1;
                        w_rin_en     = 1'b1;
                        o_done       = 1'b1;
                    end
                    OP_MVI: begin
                        w_rin_en = 1'b1;
                        o_done   = 1'b1;
                    end
                    OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                        w_bus_reg_en = 1'b1;
                        o_ain        = 1'b1;
                        w_step_next  = T2;
                    end
                    default: o_done = 1'b1;
                endcase
            end
            T2: begin
                if (is_alu_op(w_op)) begin
                    w_bus_reg_en = 1'b1;
                    w_bus_use_ry = 1'b1;
                    o_gin        = 1'b1;
                    o_alu_op     = alu_code(w_op);
                    w_step_next  = T3;
                end
            end
            T3: begin
                if (is_alu_op(w_op)) begin
                    w_sel_g  = 1'b1;
                    w_rin_en = 1'b1;
                    o_done   = 1'b1;
                end
            end
            default: o_busy = 1'b0;
        endcase
    end

    // Bus register source is Ry for mv and the second ALU operand, Rx otherwise.
    assign w_bus_reg_idx = w_bus_use_ry ? w_ry : w_rx;

    dec3to8 u_dec_rin (
        .i_en     (w_rin_en),
        .i_sel    (w_rx),
        .o_onehot (o_rin)
    );

    dec3to8 u_dec_bus (
        .i_en     (w_bus_reg_en),
        .i_sel    (w_bus_reg_idx),
        .o_onehot (w_bus_reg_onehot)
    );

    // Din is the fallback source so the select stays one-hot in every step.
    assign o_bus_sel = (w_bus_reg_en ? {2'b00, w_bus_reg_onehot} : 10'b0)
                     | (w_sel_g ? SEL_G : 10'b0)
                     | ((!w_bus_reg_en && !w_sel_g) ? SEL_DIN : 10'b0);

endmodule

// File: tb/tb_proc_control_unit.sv
// Randomized and directed bench for proc_control_unit against an instruction-level
// reference model (position within the current instruction, not FSM states).
module tb_proc_control_unit;

    logic        clk;
    logic        rst_n;
    logic        run;
    logic [15:0] din;
    logic [9:0]  bus_sel;
    logic [7:0]  rin;
    logic        ain;
    logic        gin;
    logic [1:0]  alu_op;
    logic        done;
    logic        busy;

    int checks;
    int errors;

    // Model: m_k = 0 when idle, else 1-based cycle index inside the current instruction.
    int         m_k;
    logic [8:0] m_ir;

    proc_control_unit #(.DATA_W(16), .IR_W(9)) dut (
        .i_clock  (clk),
        .i_resetn (rst_n),
        .i_run    (run),
        .i_din    (din),
        .o_bus_sel(bus_sel),
        .o_rin    (rin),
        .o_ain    (ain),
        .o_gin    (gin),
        .o_alu_op (alu_op),
        .o_done   (done),
        .o_busy   (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int instr_len(input logic [2:0] op);
        return (op >= 3'd2 && op <= 3'd5) ? 3 : 1;
    endfunction

    task automatic check_outputs(input string tag);
        logic [9:0] e_bus;
        logic [7:0] e_rin;
        logic       e_ain, e_gin, e_done;
        logic [1:0] e_aop;
        int op, x, y;
        op = int'(m_ir[8:6]);
        x  = int'(m_ir[5:3]);
        y  = int'(m_ir[2:0]);
        e_bus = 10'h200; e_rin = 8'h00; e_ain = 0; e_gin = 0; e_done = 0; e_aop = 2'b00;
        if (m_k == 1) begin
            if (op == 0) begin e_bus = 10'(1 << y); e_rin = 8'(1 << x); e_done = 1; end
            else if (op == 1) begin e_rin = 8'(1 << x); e_done = 1; end
            else if (op <= 5) begin e_bus = 10'(1 << x); e_ain = 1; end
            else e_done = 1;
        end else if (m_k == 2) begin
            e_bus = 10'(1 << y); e_gin = 1; e_aop = 2'(op - 2);
        end else if (m_k == 3) begin
            e_bus = 10'h100; e_rin = 8'(1 << x); e_done = 1;
        end
        $display("cyc %s k=%0d ir=%03b_%03b_%03b run=%0b bus=%03h rin=%02h ain=%0b gin=%0b aop=%0d done=%0b busy=%0b",
                 tag, m_k, m_ir[8:6], m_ir[5:3], m_ir[2:0], run, bus_sel, rin, ain, gin, alu_op, done, busy);
        check_eq({tag, ".bus"},    32'(bus_sel), 32'(e_bus));
        check_eq({tag, ".rin"},    32'(rin), 32'(e_rin));
        check_eq({tag, ".ain"},    32'(ain), 32'(e_ain));
        check_eq({tag, ".gin"},    32'(gin), 32'(e_gin));
        check_eq({tag, ".aluop"},  32'(alu_op), 32'(e_aop));
        check_eq({tag, ".done"},   32'(done), 32'(e_done));
        check_eq({tag, ".busy"},   32'(busy), 32'(m_k != 0));
        check_eq({tag, ".onehot"}, 32'($onehot(bus_sel)), 32'd1);
    endtask

    // One cycle: drive inputs after the falling edge, check, advance model at the rising edge.
    task automatic step_cycle(input string tag, input logic r, input logic [15:0] d);
        @(negedge clk);
        run = r;
        din = d;
        #1;
        check_outputs(tag);
        if (m_k == 0) begin
            if (r) begin
                m_ir = d[8:0];
                m_k  = 1;
            end
        end else if (m_k >= instr_len(m_ir[8:6])) begin
            m_k = 0;
        end else begin
            m_k = m_k + 1;
        end
        @(posedge clk);
    endtask

    task automatic apply_reset_mid_cycle(input string tag);
        @(negedge clk);
        run = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        m_k  = 0;
        m_ir = 9'd0;
        check_outputs({tag, ".async"});
        @(posedge clk);
        #1;
        check_outputs({tag, ".held"});
        @(negedge clk);
        run   = 1'b0;
        rst_n = 1'b1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        m_k    = 0;
        m_ir   = 9'd0;
        run    = 1'b0;
        din    = 16'h0000;
        rst_n  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Reset asserted mid-T2 of add R2,R5
        step_cycle("add_t0", 1'b1, 16'(9'b010_010_101));
        step_cycle("add_t1", 1'b0, 16'h0000);
        apply_reset_mid_cycle("rst_t2");
        step_cycle("idle", 1'b0, 16'h0000);

        // mvi R3,#0x00A5
        step_cycle("mvi_t0", 1'b1, 16'(9'b001_011_000));
        step_cycle("mvi_t1", 1'b0, 16'h00A5);

        // mv R1,R6
        step_cycle("mv_t0", 1'b1, 16'(9'b000_001_110));
        step_cycle("mv_t1", 1'b0, 16'h0000);

        // sub R4,R2
        step_cycle("sub_t0", 1'b1, 16'(9'b011_100_010));
        step_cycle("sub_t1", 1'b1, 16'hFFFF);
        step_cycle("sub_t2", 1'b1, 16'hFFFF);
        step_cycle("sub_t3", 1'b0, 16'h0000);

        // Back-to-back: add R0,R7 then or R5,R5 with Run held high
        step_cycle("b2b_add_t0", 1'b1, 16'(9'b010_000_111));
        step_cycle("b2b_add_t1", 1'b1, 16'(9'b101_101_101));
        step_cycle("b2b_add_t2", 1'b1, 16'(9'b101_101_101));
        step_cycle("b2b_add_t3", 1'b1, 16'(9'b101_101_101));
        step_cycle("b2b_or_t0",  1'b1, 16'(9'b101_101_101));
        step_cycle("b2b_or_t1",  1'b0, 16'h0000);
        step_cycle("b2b_or_t2",  1'b0, 16'h0000);
        step_cycle("b2b_or_t3",  1'b0, 16'h0000);

        // Reserved opcodes behave as a NOP
        step_cycle("res_t0", 1'b1, 16'(9'b111_010_011));
        step_cycle("res_t1", 1'b0, 16'h0000);
        step_cycle("res6_t0", 1'b1, 16'(9'b110_111_001));
        step_cycle("res6_t1", 1'b0, 16'h0000);

        // Random traffic with occasional asynchronous resets
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                apply_reset_mid_cycle("rnd_rst");
            end else begin
                step_cycle("rnd", ($urandom_range(0, 9) < 6), 16'($urandom));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
